lwe_wb_mailbox: RTL
===================

// Module: lwe_wb_mailbox
// PURPOSE
//  Wishbone-slave mailbox between the Caravel management bus and the LWE encrypt/decrypt core.
//  Packs 32-bit bus writes into DATA_WIDTH operand beats and queues them in a FIFO.
//  Issues opcodes to the core with a busy/done handshake, and unpacks DATA_WIDTH results into 32-bit bus reads.
//  Generalises the fixed opcode/output decode of the current top to parametrised widths, depth, a status word and flush.
// PARAMETERS
//  DATA_WIDTH   128           core-side beat width; multiple of 32
//  FIFO_DEPTH   8             input beat FIFO depth; power of 2, >=2
//  OP_WIDTH     4             opcode field width, taken from dat[OP_WIDTH-1:0]
//  OPCODE_ADDR  32'h30000000  write: opcode/flush; read: status
//  INPUT_ADDR   32'h20000000  write: operand word
//  OUTPUT_ADDR  32'h10000000  read: result word
// PORTS
//  clk        in   1           single clock; the Wishbone side runs on this clock too
//  rst_n      in   1           asynchronous, active-low reset
//  wbs_stb_i  in   1           Wishbone strobe
//  wbs_cyc_i  in   1           Wishbone cycle
//  wbs_we_i   in   1           1 = write
//  wbs_sel_i  in   4           byte selects; ignored, full-word access only
//  wbs_adr_i  in   32          byte address; compared for exact equality with the *_ADDR parameters
//  wbs_dat_i  in   32          write data
//  wbs_ack_o  out  1           single-cycle acknowledge
//  wbs_dat_o  out  32          read data; 0 whenever wbs_ack_o=0
//  op_o       out  OP_WIDTH    opcode held for the core
//  start_o    out  1           1-cycle pulse when an opcode is accepted
//  done_i     in   1           core completion pulse
//  in_data_o  out  DATA_WIDTH  FIFO head beat
//  in_valid_o out  1           FIFO not empty
//  in_ready_i in   1           core pops the beat when in_valid_o & in_ready_i
//  out_data_i in   DATA_WIDTH  core result beat
//  out_valid_i in  1           core offers a result
//  out_ready_o out 1           result buffer empty
// BEHAVIOUR
//  Reset: all outputs 0; FIFO, pack counter, unpack counter, busy and err cleared; out_ready_o returns to 1 on the first clk after reset release.
//  Bus request: accepted when stb&cyc&!ack. ack is raised 1 cycle later and dropped the cycle after that.
//  Unmapped address: acked with read data 0 and no side effect.
//  INPUT write: word k (pack counter k = 0..W-1, W = DATA_WIDTH/32) lands in beat bits [32k+31:32k].
//   On the word with k = W-1 the beat is pushed into the FIFO and k wraps to 0.
//   If the FIFO is full on the last word, ack is withheld (wait state) until a pop frees a slot; the push then happens with ack.
//   A pop and a push in the same cycle are both allowed when the FIFO is full.
//  OPCODE write:
//   If dat[31]=1: flush. Clears the FIFO, both counters, the result buffer and err. busy is untouched.
//   Else if !busy: op_o <= dat[OP_WIDTH-1:0]; start_o pulses in the ack cycle; busy <= 1.
//   Else (busy): write is ignored, err <= 1 (sticky).
//  done_i: busy <= 0 next cycle. If done_i and an opcode accept coincide, the accept is evaluated with busy=1, so it is rejected and sets err.
//  Status read at OPCODE_ADDR: {23'b0, pack_cnt[3:0], err, res_valid, fifo_full, fifo_empty, busy}; pack_cnt is zero-extended.
//  Result path: out_ready_o = !res_valid. out_valid_i & out_ready_o loads the buffer, res_valid <= 1.
//   OUTPUT read returns word j = buffer[32j+31:32j] and increments j. After word W-1 is read, j wraps to 0 and res_valid <= 0.
//   An OUTPUT read with res_valid=0 returns 0 and does not advance j.
//  Latency: INPUT write to in_valid_o is 2 cycles after the accept of the last word when the FIFO was empty.
//  Reset mid-transaction: ack is dropped immediately and partially packed or unpacked words are lost.
// TESTING
//  T1: write 4 words 1,2,3,4 to INPUT_ADDR, in_ready_i=0 -> in_data_o=128'h00000004_00000003_00000002_00000001, in_valid_o=1.
//  T2: fill 8 beats with in_ready_i=0, then write the 32nd+4th word -> ack stalls; in_ready_i pulses 1 cycle -> ack within 2 cycles, FIFO count stays 8.
//  T3: write opcode 5 -> op_o=5, one start_o pulse, status=0x1|empty bits. Write opcode 3 before done_i -> op_o stays 5, err=1. done_i -> busy=0.
//  T4: core presents out_data_i=128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D -> reads give CAFEF00D, 89ABCDEF, 01234567, DEADBEEF; the 5th read gives 0; out_ready_o=1 again.
//  T5: write 2 INPUT words, then write 32'h80000000 to OPCODE_ADDR -> pack_cnt=0, FIFO empty, err=0; the next 4 words form a clean beat.
//  T6: assert rst_n=0 during a stalled ack in T2 -> ack=0 and in_valid_o=0 immediately; status reads 0x2 after release.

Source files
------------

// File: rtl/lwe_wb_mailbox.sv
// ---------------------------------------------------------------------------
// lwe_wb_mailbox
//
// Wishbone-slave mailbox between the management bus and the LWE core.
//  - 32-bit writes to INPUT_ADDR are packed, low word first, into DATA_WIDTH
//    operand beats. Each complete beat is queued in a FIFO_DEPTH-entry FIFO.
//  - Writes to OPCODE_ADDR either flush the mailbox (dat[31]=1) or issue an
//    opcode to the core. An opcode is issued only while the core is idle.
//    Reads of OPCODE_ADDR return a status word.
//  - Results from the core are captured into a single DATA_WIDTH buffer.
//    Reads of OUTPUT_ADDR return the buffer 32 bits at a time, low word first.
//
// Ports
//  clk, rst_n                 clock, asynchronous active-low reset
//  wbs_stb_i/cyc_i/we_i       Wishbone request qualifiers
//  wbs_sel_i                  byte selects (ignored, full-word access only)
//  wbs_adr_i/dat_i            byte address and write data
//  wbs_ack_o/dat_o            single-cycle acknowledge; read data is 0 when
//                             no acknowledge is given
//  op_o, start_o              held opcode and its one-cycle start pulse
//  done_i                     core completion pulse
//  in_data_o/valid_o/ready_i  operand beat stream to the core (FIFO head)
//  out_data_i/valid_i/ready_o result beat stream from the core
// ---------------------------------------------------------------------------
module lwe_wb_mailbox #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned OP_WIDTH    = 4,
    parameter logic [31:0] OPCODE_ADDR = 32'h3000_0000,
    parameter logic [31:0] INPUT_ADDR  = 32'h2000_0000,
    parameter logic [31:0] OUTPUT_ADDR = 32'h1000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic [OP_WIDTH-1:0]   op_o,
    output logic                  start_o,
    input  logic                  done_i,
    output logic [DATA_WIDTH-1:0] in_data_o,
    output logic                  in_valid_o,
    input  logic                  in_ready_i,
    input  logic [DATA_WIDTH-1:0] out_data_i,
    input  logic                  out_valid_i,
    output logic                  out_ready_o
);

    localparam int unsigned WORDS  = DATA_WIDTH / 32;
    localparam int unsigned CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1'b1);
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(1'b1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    // Pack counter as it appears in the 4-bit status field (zero-extended).
    function automatic logic [3:0] pack_nibble(input logic [CNT_W-1:0] cnt);
        return 4'(cnt);
    endfunction

    // ---------------- registers ----------------
    logic                  ack_q,       ack_d;
    logic [31:0]           rdat_q,      rdat_d;
    logic [OP_WIDTH-1:0]   op_q,        op_d;
    logic                  start_q,     start_d;
    logic                  busy_q,      busy_d;
    logic                  err_q,       err_d;
    logic [CNT_W-1:0]      pack_cnt_q,  pack_cnt_d;
    logic [DATA_WIDTH-1:0] beat_q,      beat_d;
    logic [PTR_W-1:0]      wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q,    rd_ptr_d;
    logic [FCNT_W-1:0]     fifo_cnt_q,  fifo_cnt_d;
    logic                  in_valid_q,  in_valid_d;
    logic [DATA_WIDTH-1:0] in_data_q,   in_data_d;
    logic [DATA_WIDTH-1:0] res_q,       res_d;
    logic                  res_valid_q, res_valid_d;
    logic [CNT_W-1:0]      unpack_q,    unpack_d;
    logic                  out_ready_q, out_ready_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // ---------------- decode ----------------
    logic        bus_req_s, hit_op_s, hit_in_s, hit_out_s;
    logic        last_word_s, fifo_full_s, fifo_empty_s;
    logic        pop_s, in_wr_s, stall_s, accept_s, push_s;
    logic        op_wr_s, flush_s, res_rd_s, res_load_s;
    logic [31:0] status_s, res_word_s;
    logic        sel_unused_s;

    assign sel_unused_s = ^wbs_sel_i;

    // Bus request decode, FIFO flags and the wait-state decision.
    always_comb begin
        bus_req_s    = wbs_stb_i & wbs_cyc_i & ~ack_q;
        hit_op_s     = (wbs_adr_i == OPCODE_ADDR);
        hit_in_s     = (wbs_adr_i == INPUT_ADDR);
        hit_out_s    = (wbs_adr_i == OUTPUT_ADDR);
        last_word_s  = (pack_cnt_q == LAST_WORD);
        fifo_full_s  = (fifo_cnt_q == FULL_CNT);
        fifo_empty_s = (fifo_cnt_q == {FCNT_W{1'b0}});
        pop_s        = in_valid_q & in_ready_i;
        in_wr_s      = bus_req_s & wbs_we_i & hit_in_s;
        // The word completing a beat waits while the FIFO is full, unless
        // the core frees a slot in this very cycle.
        stall_s      = in_wr_s & last_word_s & fifo_full_s & ~pop_s;
        accept_s     = bus_req_s & ~stall_s;
        push_s       = accept_s & wbs_we_i & hit_in_s & last_word_s;
        op_wr_s      = accept_s & wbs_we_i & hit_op_s;
        flush_s      = op_wr_s & wbs_dat_i[31];
        res_rd_s     = accept_s & ~wbs_we_i & hit_out_s & res_valid_q;
        res_load_s   = out_valid_i & out_ready_q;
        res_word_s   = res_q[{unpack_q, 5'b00000} +: 32];
        status_s     = {23'd0, pack_nibble(pack_cnt_q), err_q, res_valid_q,
                        fifo_full_s, fifo_empty_s, busy_q};
    end

    // Acknowledge, read data mux and the opcode/busy/err handshake.
    always_comb begin
        ack_d   = accept_s;
        rdat_d  = 32'd0;
        op_d    = op_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        err_d   = err_q;

        if (accept_s && !wbs_we_i) begin
            if (hit_op_s) begin
                rdat_d = status_s;
            end else if (hit_out_s && res_valid_q) begin
                rdat_d = res_word_s;
            end else begin
                rdat_d = 32'd0;
            end
        end else begin
            rdat_d = 32'd0;
        end

        if (done_i) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end

        // An opcode accept uses the registered busy, so a done_i in the
        // same cycle does not let the new opcode through.
        if (flush_s) begin
            err_d = 1'b0;
        end else if (op_wr_s && !busy_q) begin
            op_d    = wbs_dat_i[OP_WIDTH-1:0];
            start_d = 1'b1;
            busy_d  = 1'b1;
        end else if (op_wr_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Operand packing and the beat FIFO pointers/occupancy.
    always_comb begin
        pack_cnt_d = pack_cnt_q;
        beat_d     = beat_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        in_valid_d = 1'b0;
        in_data_d  = {DATA_WIDTH{1'b0}};

        if (flush_s) begin
            pack_cnt_d = {CNT_W{1'b0}};
            beat_d     = {DATA_WIDTH{1'b0}};
        end else if (accept_s && wbs_we_i && hit_in_s) begin
            beat_d[{pack_cnt_q, 5'b00000} +: 32] = wbs_dat_i;
            if (last_word_s) begin
                pack_cnt_d = {CNT_W{1'b0}};
            end else begin
                pack_cnt_d = pack_cnt_q + CNT_ONE;
            end
        end else begin
            pack_cnt_d = pack_cnt_q;
        end

        if (flush_s) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            fifo_cnt_d = {FCNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_ONE;
                2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_ONE;
                default: fifo_cnt_d = fifo_cnt_q;
            endcase
        end

        // The head register only presents beats already stored before this
        // edge, so a freshly pushed beat appears one cycle after the push.
        if (flush_s) begin
            in_valid_d = 1'b0;
        end else if (pop_s) begin
            in_valid_d = (fifo_cnt_q != FCNT_ONE);
        end else begin
            in_valid_d = !fifo_empty_s;
        end

        if (in_valid_d) begin
            in_data_d = mem_q[rd_ptr_d];
        end else begin
            in_data_d = {DATA_WIDTH{1'b0}};
        end
    end

    // Result buffer capture and word-by-word unpacking.
    always_comb begin
        res_d       = res_q;
        res_valid_d = res_valid_q;
        unpack_d    = unpack_q;

        if (flush_s) begin
            res_d       = {DATA_WIDTH{1'b0}};
            res_valid_d = 1'b0;
            unpack_d    = {CNT_W{1'b0}};
        end else if (res_rd_s) begin
            if (unpack_q == LAST_WORD) begin
                unpack_d    = {CNT_W{1'b0}};
                res_valid_d = 1'b0;
            end else begin
                unpack_d    = unpack_q + CNT_ONE;
            end
        end else if (res_load_s) begin
            res_d       = out_data_i;
            res_valid_d = 1'b1;
            unpack_d    = {CNT_W{1'b0}};
        end else begin
            res_valid_d = res_valid_q;
        end

        out_ready_d = ~res_valid_d;
    end

    // State register bank with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q       <= 1'b0;
            rdat_q      <= 32'd0;
            op_q        <= {OP_WIDTH{1'b0}};
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pack_cnt_q  <= {CNT_W{1'b0}};
            beat_q      <= {DATA_WIDTH{1'b0}};
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            fifo_cnt_q  <= {FCNT_W{1'b0}};
            in_valid_q  <= 1'b0;
            in_data_q   <= {DATA_WIDTH{1'b0}};
            res_q       <= {DATA_WIDTH{1'b0}};
            res_valid_q <= 1'b0;
            unpack_q    <= {CNT_W{1'b0}};
            out_ready_q <= 1'b0;
        end else begin
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
            op_q        <= op_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pack_cnt_q  <= pack_cnt_d;
            beat_q      <= beat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            in_valid_q  <= in_valid_d;
            in_data_q   <= in_data_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            unpack_q    <= unpack_d;
            out_ready_q <= out_ready_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= beat_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdat_q;
    assign op_o        = op_q;
    assign start_o     = start_q;
    assign in_data_o   = in_data_q;
    assign in_valid_o  = in_valid_q;
    assign out_ready_o = out_ready_q;

endmodule
